id_ex_stage: RTL and testbench
==============================

// Module: id_ex_stage
// PURPOSE
//  ID/EX pipeline register directly upstream of the ALU. Latches decoded operands and control each cycle.
//  Drives SrcA/SrcB/Operation into the ALU, with EX/MEM and MEM/WB operand forwarding.
//  Detects load-use hazards: inserts one bubble and tells IF/ID to hold. Also honours branch flush.
//  Keeps a saturating stall counter for performance debug.
// PARAMETERS
//  DATA_WIDTH     32  operand/result width
//  OPCODE_LENGTH  4   ALU Operation code width
//  REG_ADDR       5   register index width
//  CNT_WIDTH      16  stall counter width
// PORTS
//  clk             in   1              rising-edge clock
//  reset           in   1              synchronous, active-high
//  flush_i         in   1              branch taken: kill instruction entering EX
//  id_pc           in   DATA_WIDTH     PC of ID instruction
//  id_rs1_data     in   DATA_WIDTH     regfile read port 1
//  id_rs2_data     in   DATA_WIDTH     regfile read port 2
//  id_imm          in   DATA_WIDTH     sign-extended immediate
//  id_rs1,id_rs2   in   REG_ADDR       source indices
//  id_rd           in   REG_ADDR       destination index
//  id_use_rs1      in   1              instruction reads rs1
//  id_use_rs2      in   1              instruction reads rs2
//  id_alu_op       in   OPCODE_LENGTH  ALU operation code
//  id_alu_src      in   1              1: SrcB = imm, 0: SrcB = rs2
//  id_mem_read     in   1              load
//  id_mem_write    in   1              store
//  id_reg_write    in   1              writes rd
//  exmem_reg_write in   1              EX/MEM writes rd
//  exmem_rd        in   REG_ADDR       EX/MEM destination
//  exmem_result    in   DATA_WIDTH     EX/MEM ALU result
//  memwb_reg_write in   1              MEM/WB writes rd
//  memwb_rd        in   REG_ADDR       MEM/WB destination
//  memwb_wb_data   in   DATA_WIDTH     MEM/WB writeback value
//  SrcA,SrcB       out  DATA_WIDTH     ALU operands (forwarded)
//  Operation       out  OPCODE_LENGTH  ALU operation
//  ex_store_data   out  DATA_WIDTH     forwarded rs2 for stores
//  ex_pc           out  DATA_WIDTH     registered PC
//  ex_rd           out  REG_ADDR       registered rd
//  ex_reg_write    out  1              registered control
//  ex_mem_read     out  1              registered control
//  ex_mem_write    out  1              registered control
//  stall_o         out  1              hold PC and IF/ID this cycle
//  stall_count     out  CNT_WIDTH      bubbles inserted by load-use hazards
// BEHAVIOUR
//  - Reset (sync): all registered fields = 0 (Operation=4'b0000, rd=0, controls=0); stall_count=0.
//    While reset is high, stall_o=0.
//  - Load-use hazard (combinational): stall_o = ex_mem_read & ex_rd!=0 &
//      ((id_use_rs1 & id_rs1==ex_rd) | (id_use_rs2 & id_rs2==ex_rd)) & ~flush_i.
//  - Each edge, if flush_i or stall_o, load a bubble: controls=0, rd=0, Operation=0, data=0.
//    Otherwise latch all id_* fields. Latency ID->EX = 1 cycle.
//  - flush_i and hazard together: flush wins, stall_o=0, one bubble.
//  - stall_count increments by 1 on each edge where stall_o=1; saturates at all-ones and never wraps.
//  - Forwarding is combinational from the registered rs1/rs2 indices:
//    - EX/MEM hit: exmem_reg_write & exmem_rd!=0 & exmem_rd==ex_rsN -> exmem_result.
//    - Else MEM/WB hit: the same test on memwb_* -> memwb_wb_data.
//    - Else the registered regfile data. EX/MEM has priority over MEM/WB. Index x0 never forwards.
//  - SrcA = fwdA. SrcB = ex_alu_src ? ex_imm : fwdB. ex_store_data = fwdB regardless of alu_src.
//  - No arithmetic here; all values pass at full DATA_WIDTH.
// TESTING
//  1 Reset: hold reset 2 cycles with nonzero id_*.
//    -> all outputs 0, stall_o=0, stall_count=0.
//  2 Pass-through: id_alu_op=4'b0010, rs1_data=5, imm=7, alu_src=1, no hazards.
//    -> next cycle SrcA=5, SrcB=7, Operation=0010.
//  3 Forward priority: ex_rs1=3; exmem_rd=3 (result 0xAA); memwb_rd=3 (data 0xBB); both writing.
//    -> SrcA=0xAA. Drop exmem_reg_write -> SrcA=0xBB. Set rd=0 -> no forward.
//  4 Load-use: lw x5 in EX, ID uses rs2=x5.
//    -> stall_o=1 for exactly 1 cycle; bubble in EX; stall_count 0->1.
//    -> Next cycle x5 arrives from EX/MEM (forwarded).
//  5 Flush+hazard same cycle.
//    -> stall_o=0, bubble latched, stall_count unchanged.
//  6 Saturation: preload stall_count to all-ones via 2^CNT_WIDTH hazards (CNT_WIDTH=4 bench).
//    -> stays 4'hF on further stalls.

Source files
------------

// File: rtl/id_ex_if.sv
// rtl/id_ex_if.sv - ID/EX stage bundle: decoded ID inputs, forwarding sources and EX-side outputs
//
// Purpose: carries every non-clock/reset signal of the ID/EX pipeline register.
// Ports (modport slave = stage view, master = driver view):
//   flush_i, id_* (pc, rs1/rs2 data, imm, rs1/rs2/rd indices, use_rs1/2,
//     alu_op, alu_src, mem_read, mem_write, reg_write)       ID -> stage
//   exmem_reg_write/rd/result, memwb_reg_write/rd/wb_data       forwarding sources
//   SrcA, SrcB, Operation                                       stage -> ALU
//   ex_store_data, ex_pc, ex_rd, ex_reg_write, ex_mem_read,
//     ex_mem_write                                              stage -> EX/MEM
//   stall_o, stall_count                                        hazard / debug
interface id_ex_if #(
  parameter int DATA_WIDTH    = 32,
  parameter int OPCODE_LENGTH = 4,
  parameter int REG_ADDR      = 5,
  parameter int CNT_WIDTH     = 16
);
  logic                     flush_i;
  logic [DATA_WIDTH-1:0]    id_pc;
  logic [DATA_WIDTH-1:0]    id_rs1_data;
  logic [DATA_WIDTH-1:0]    id_rs2_data;
  logic [DATA_WIDTH-1:0]    id_imm;
  logic [REG_ADDR-1:0]      id_rs1;
  logic [REG_ADDR-1:0]      id_rs2;
  logic [REG_ADDR-1:0]      id_rd;
  logic                     id_use_rs1;
  logic                     id_use_rs2;
  logic [OPCODE_LENGTH-1:0] id_alu_op;
  logic                     id_alu_src;
  logic                     id_mem_read;
  logic                     id_mem_write;
  logic                     id_reg_write;
  logic                     exmem_reg_write;
  logic [REG_ADDR-1:0]      exmem_rd;
  logic [DATA_WIDTH-1:0]    exmem_result;
  logic                     memwb_reg_write;
  logic [REG_ADDR-1:0]      memwb_rd;
  logic [DATA_WIDTH-1:0]    memwb_wb_data;
  logic [DATA_WIDTH-1:0]    SrcA;
  logic [DATA_WIDTH-1:0]    SrcB;
  logic [OPCODE_LENGTH-1:0] Operation;
  logic [DATA_WIDTH-1:0]    ex_store_data;
  logic [DATA_WIDTH-1:0]    ex_pc;
  logic [REG_ADDR-1:0]      ex_rd;
  logic                     ex_reg_write;
  logic                     ex_mem_read;
  logic                     ex_mem_write;
  logic                     stall_o;
  logic [CNT_WIDTH-1:0]     stall_count;

  modport slave (
    input  flush_i, id_pc, id_rs1_data, id_rs2_data, id_imm, id_rs1, id_rs2, id_rd,
           id_use_rs1, id_use_rs2, id_alu_op, id_alu_src, id_mem_read, id_mem_write,
           id_reg_write, exmem_reg_write, exmem_rd, exmem_result,
           memwb_reg_write, memwb_rd, memwb_wb_data,
    output SrcA, SrcB, Operation, ex_store_data, ex_pc, ex_rd, ex_reg_write,
           ex_mem_read, ex_mem_write, stall_o, stall_count
  );

  modport master (
    output flush_i, id_pc, id_rs1_data, id_rs2_data, id_imm, id_rs1, id_rs2, id_rd,
           id_use_rs1, id_use_rs2, id_alu_op, id_alu_src, id_mem_read, id_mem_write,
           id_reg_write, exmem_reg_write, exmem_rd, exmem_result,
           memwb_reg_write, memwb_rd, memwb_wb_data,
    input  SrcA, SrcB, Operation, ex_store_data, ex_pc, ex_rd, ex_reg_write,
           ex_mem_read, ex_mem_write, stall_o, stall_count
  );
endinterface

// File: rtl/id_ex_stage.sv
// rtl/id_ex_stage.sv - ID/EX pipeline register with operand forwarding and load-use stall
//
// Purpose: latches decoded operands/control for the ALU, forwards EX/MEM and
// MEM/WB results onto the operands, inserts one bubble on a load-use hazard
// (raising stall_o so IF/ID holds), honours branch flush, and counts stalls
// in a saturating counter.
// Ports:
//   clk    rising-edge clock
//   reset  synchronous, active-high
//   bus    id_ex_if.slave bundle (ID inputs, forwarding sources, ALU/EX outputs)
module id_ex_stage #(
  parameter int DATA_WIDTH    = 32,
  parameter int OPCODE_LENGTH = 4,
  parameter int REG_ADDR      = 5,
  parameter int CNT_WIDTH     = 16
) (
  input  logic  clk,
  input  logic  reset,
  id_ex_if.slave bus
);

  logic [DATA_WIDTH-1:0]    pc_q;
  logic [DATA_WIDTH-1:0]    rs1_data_q;
  logic [DATA_WIDTH-1:0]    rs2_data_q;
  logic [DATA_WIDTH-1:0]    imm_q;
  logic [REG_ADDR-1:0]      rs1_q;
  logic [REG_ADDR-1:0]      rs2_q;
  logic [REG_ADDR-1:0]      rd_q;
  logic [OPCODE_LENGTH-1:0] alu_op_q;
  logic                     alu_src_q;
  logic                     mem_read_q;
  logic                     mem_write_q;
  logic                     reg_write_q;
  logic [CNT_WIDTH-1:0]     stall_cnt_q;

  logic                     load_use;
  logic                     stall;
  logic                     bubble;
  logic [DATA_WIDTH-1:0]    fwd_a;
  logic [DATA_WIDTH-1:0]    fwd_b;

  // A load in EX whose rd is consumed by the ID instruction cannot be
  // forwarded in time; flush overrides because the ID instruction dies anyway.
  assign load_use = mem_read_q && (rd_q != '0) &&
                    ((bus.id_use_rs1 && (bus.id_rs1 == rd_q)) ||
                     (bus.id_use_rs2 && (bus.id_rs2 == rd_q)));
  assign stall    = load_use && !bus.flush_i && !reset;
  assign bubble   = bus.flush_i || stall;

  always_ff @(posedge clk) begin
    if (reset || bubble) begin
      pc_q        <= '0;
      rs1_data_q  <= '0;
      rs2_data_q  <= '0;
      imm_q       <= '0;
      rs1_q       <= '0;
      rs2_q       <= '0;
      rd_q        <= '0;
      alu_op_q    <= '0;
      alu_src_q   <= 1'b0;
      mem_read_q  <= 1'b0;
      mem_write_q <= 1'b0;
      reg_write_q <= 1'b0;
    end else begin
      pc_q        <= bus.id_pc;
      rs1_data_q  <= bus.id_rs1_data;
      rs2_data_q  <= bus.id_rs2_data;
      imm_q       <= bus.id_imm;
      rs1_q       <= bus.id_rs1;
      rs2_q       <= bus.id_rs2;
      rd_q        <= bus.id_rd;
      alu_op_q    <= bus.id_alu_op;
      alu_src_q   <= bus.id_alu_src;
      mem_read_q  <= bus.id_mem_read;
      mem_write_q <= bus.id_mem_write;
      reg_write_q <= bus.id_reg_write;
    end

    // Saturating: a wrapped debug counter would under-report heavy stalling.
    if (reset) begin
      stall_cnt_q <= '0;
    end else if (stall && (stall_cnt_q != '1)) begin
      stall_cnt_q <= stall_cnt_q + {{(CNT_WIDTH-1){1'b0}}, 1'b1};
    end
  end

  // EX/MEM holds the younger result, so it takes priority; x0 never forwards.
  always_comb begin
    fwd_a = rs1_data_q;
    if (bus.exmem_reg_write && (bus.exmem_rd != '0) && (bus.exmem_rd == rs1_q)) begin
      fwd_a = bus.exmem_result;
    end else if (bus.memwb_reg_write && (bus.memwb_rd != '0) && (bus.memwb_rd == rs1_q)) begin
      fwd_a = bus.memwb_wb_data;
    end
  end

  always_comb begin
    fwd_b = rs2_data_q;
    if (bus.exmem_reg_write && (bus.exmem_rd != '0) && (bus.exmem_rd == rs2_q)) begin
      fwd_b = bus.exmem_result;
    end else if (bus.memwb_reg_write && (bus.memwb_rd != '0) && (bus.memwb_rd == rs2_q)) begin
      fwd_b = bus.memwb_wb_data;
    end
  end

  assign bus.SrcA          = fwd_a;
  assign bus.SrcB          = alu_src_q ? imm_q : fwd_b;
  assign bus.ex_store_data = fwd_b;
  assign bus.Operation     = alu_op_q;
  assign bus.ex_pc         = pc_q;
  assign bus.ex_rd         = rd_q;
  assign bus.ex_reg_write  = reg_write_q;
  assign bus.ex_mem_read   = mem_read_q;
  assign bus.ex_mem_write  = mem_write_q;
  assign bus.stall_o       = stall;
  assign bus.stall_count   = stall_cnt_q;

endmodule

// File: tb/tb_id_ex_stage.sv
// tb/tb_id_ex_stage.sv - directed self-checking bench for id_ex_stage
module tb_id_ex_stage;

  logic clk;
  logic reset;
  int   checks;
  int   errors;
  int   exp_cnt;

  id_ex_if #(.DATA_WIDTH(32), .OPCODE_LENGTH(4), .REG_ADDR(5), .CNT_WIDTH(4)) bus ();

  id_ex_stage #(.DATA_WIDTH(32), .OPCODE_LENGTH(4), .REG_ADDR(5), .CNT_WIDTH(4)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    bus.flush_i         = 1'b0;
    bus.id_pc           = '0;
    bus.id_rs1_data     = '0;
    bus.id_rs2_data     = '0;
    bus.id_imm          = '0;
    bus.id_rs1          = '0;
    bus.id_rs2          = '0;
    bus.id_rd           = '0;
    bus.id_use_rs1      = 1'b0;
    bus.id_use_rs2      = 1'b0;
    bus.id_alu_op       = '0;
    bus.id_alu_src      = 1'b0;
    bus.id_mem_read     = 1'b0;
    bus.id_mem_write    = 1'b0;
    bus.id_reg_write    = 1'b0;
    bus.exmem_reg_write = 1'b0;
    bus.exmem_rd        = '0;
    bus.exmem_result    = '0;
    bus.memwb_reg_write = 1'b0;
    bus.memwb_rd        = '0;
    bus.memwb_wb_data   = '0;
  endtask

  // Put a load "lw x<rd>" into ID so it lands in EX after the next edge.
  task automatic issue_load(input logic [4:0] rd);
    clear_inputs();
    bus.id_rd        = rd;
    bus.id_rs1       = 5'd1;
    bus.id_use_rs1   = 1'b1;
    bus.id_mem_read  = 1'b1;
    bus.id_reg_write = 1'b1;
    bus.id_alu_op    = 4'b0010;
    tick();
  endtask

  task automatic test_reset();
    reset = 1'b1;
    clear_inputs();
    bus.id_pc = 32'h1234; bus.id_rs1_data = 32'h55; bus.id_rs2_data = 32'h66;
    bus.id_imm = 32'h77; bus.id_rs1 = 5'd3; bus.id_rs2 = 5'd4; bus.id_rd = 5'd9;
    bus.id_use_rs1 = 1'b1; bus.id_alu_op = 4'b0110; bus.id_alu_src = 1'b1;
    bus.id_mem_read = 1'b1; bus.id_mem_write = 1'b1; bus.id_reg_write = 1'b1;
    tick();
    tick();
    checks++;
    if ({bus.SrcA, bus.SrcB, bus.ex_store_data, bus.ex_pc} !== 128'h0) begin
      errors++;
      $display("FAIL reset_data got SrcA=%h SrcB=%h st=%h pc=%h expected all 0",
               bus.SrcA, bus.SrcB, bus.ex_store_data, bus.ex_pc);
    end
    checks++;
    if ({bus.Operation, bus.ex_rd, bus.ex_reg_write, bus.ex_mem_read, bus.ex_mem_write} !== 12'h0) begin
      errors++;
      $display("FAIL reset_ctrl got op=%h rd=%h rw=%b mr=%b mw=%b expected all 0",
               bus.Operation, bus.ex_rd, bus.ex_reg_write, bus.ex_mem_read, bus.ex_mem_write);
    end
    checks++;
    if (bus.stall_o !== 1'b0 || bus.stall_count !== 4'h0) begin
      errors++;
      $display("FAIL reset_stall got stall_o=%b count=%h expected 0 0", bus.stall_o, bus.stall_count);
    end
    reset = 1'b0;
    exp_cnt = 0;
  endtask

  task automatic test_pass_through();
    clear_inputs();
    bus.id_pc = 32'h100; bus.id_alu_op = 4'b0010; bus.id_rs1_data = 32'd5;
    bus.id_rs2_data = 32'd9; bus.id_imm = 32'd7; bus.id_alu_src = 1'b1;
    bus.id_rs1 = 5'd1; bus.id_rs2 = 5'd2; bus.id_use_rs1 = 1'b1;
    bus.id_rd = 5'd4; bus.id_reg_write = 1'b1;
    tick();
    checks++;
    if (bus.SrcA !== 32'd5 || bus.SrcB !== 32'd7 || bus.Operation !== 4'b0010) begin
      errors++;
      $display("FAIL pass_alu got SrcA=%0d SrcB=%0d op=%b expected 5 7 0010",
               bus.SrcA, bus.SrcB, bus.Operation);
    end
    checks++;
    if (bus.ex_pc !== 32'h100 || bus.ex_rd !== 5'd4 || bus.ex_reg_write !== 1'b1 ||
        bus.ex_store_data !== 32'd9) begin
      errors++;
      $display("FAIL pass_ex got pc=%h rd=%0d rw=%b st=%0d expected 100 4 1 9",
               bus.ex_pc, bus.ex_rd, bus.ex_reg_write, bus.ex_store_data);
    end
    // Store form: SrcB takes rs2 when alu_src=0.
    bus.id_alu_src = 1'b0; bus.id_mem_write = 1'b1; bus.id_reg_write = 1'b0;
    tick();
    checks++;
    if (bus.SrcB !== 32'd9 || bus.ex_mem_write !== 1'b1 || bus.ex_reg_write !== 1'b0) begin
      errors++;
      $display("FAIL pass_rs2 got SrcB=%0d mw=%b rw=%b expected 9 1 0",
               bus.SrcB, bus.ex_mem_write, bus.ex_reg_write);
    end
  endtask

  task automatic test_forward_priority();
    clear_inputs();
    bus.id_rs1 = 5'd3; bus.id_rs1_data = 32'h11; bus.id_use_rs1 = 1'b1;
    bus.id_rs2 = 5'd3; bus.id_rs2_data = 32'h22; bus.id_use_rs2 = 1'b1;
    bus.id_imm = 32'h99; bus.id_alu_src = 1'b1;
    tick();
    clear_inputs();
    bus.exmem_reg_write = 1'b1; bus.exmem_rd = 5'd3; bus.exmem_result = 32'hAA;
    bus.memwb_reg_write = 1'b1; bus.memwb_rd = 5'd3; bus.memwb_wb_data = 32'hBB;
    #1;
    checks++;
    if (bus.SrcA !== 32'hAA || bus.ex_store_data !== 32'hAA || bus.SrcB !== 32'h99) begin
      errors++;
      $display("FAIL fwd_exmem got SrcA=%h st=%h SrcB=%h expected aa aa 99",
               bus.SrcA, bus.ex_store_data, bus.SrcB);
    end
    bus.exmem_reg_write = 1'b0;
    #1;
    checks++;
    if (bus.SrcA !== 32'hBB || bus.ex_store_data !== 32'hBB) begin
      errors++;
      $display("FAIL fwd_memwb got SrcA=%h st=%h expected bb bb", bus.SrcA, bus.ex_store_data);
    end
    bus.exmem_reg_write = 1'b1; bus.exmem_rd = 5'd0; bus.memwb_rd = 5'd0;
    #1;
    checks++;
    if (bus.SrcA !== 32'h11 || bus.ex_store_data !== 32'h22) begin
      errors++;
      $display("FAIL fwd_none got SrcA=%h st=%h expected 11 22", bus.SrcA, bus.ex_store_data);
    end
  endtask

  task automatic test_load_use();
    issue_load(5'd5);
    // Dependent add in ID: rs2 = x5.
    clear_inputs();
    bus.id_rs1 = 5'd2; bus.id_rs1_data = 32'h3; bus.id_use_rs1 = 1'b1;
    bus.id_rs2 = 5'd5; bus.id_rs2_data = 32'hDEAD; bus.id_use_rs2 = 1'b1;
    bus.id_rd = 5'd6; bus.id_reg_write = 1'b1; bus.id_alu_op = 4'b0010;
    #1;
    checks++;
    if (bus.stall_o !== 1'b1 || bus.stall_count !== 4'(exp_cnt)) begin
      errors++;
      $display("FAIL lu_stall got stall_o=%b count=%0d expected 1 %0d",
               bus.stall_o, bus.stall_count, exp_cnt);
    end
    tick();
    exp_cnt++;
    // Load moved to EX/MEM; the bubble now sits in EX.
    bus.exmem_reg_write = 1'b1; bus.exmem_rd = 5'd5; bus.exmem_result = 32'h55;
    #1;
    checks++;
    if (bus.stall_o !== 1'b0 || bus.ex_rd !== 5'd0 || bus.ex_reg_write !== 1'b0 ||
        bus.ex_mem_read !== 1'b0 || bus.Operation !== 4'b0000) begin
      errors++;
      $display("FAIL lu_bubble got stall_o=%b rd=%0d rw=%b mr=%b op=%b expected 0 0 0 0 0000",
               bus.stall_o, bus.ex_rd, bus.ex_reg_write, bus.ex_mem_read, bus.Operation);
    end
    checks++;
    if (bus.stall_count !== 4'(exp_cnt)) begin
      errors++;
      $display("FAIL lu_count got %0d expected %0d", bus.stall_count, exp_cnt);
    end
    tick();
    checks++;
    if (bus.SrcB !== 32'h55 || bus.ex_store_data !== 32'h55 || bus.SrcA !== 32'h3 ||
        bus.ex_rd !== 5'd6) begin
      errors++;
      $display("FAIL lu_forward got SrcA=%h SrcB=%h st=%h rd=%0d expected 3 55 55 6",
               bus.SrcA, bus.SrcB, bus.ex_store_data, bus.ex_rd);
    end
  endtask

  task automatic test_flush_hazard();
    issue_load(5'd6);
    clear_inputs();
    bus.id_rs1 = 5'd6; bus.id_use_rs1 = 1'b1; bus.id_rd = 5'd8;
    bus.id_reg_write = 1'b1; bus.id_alu_op = 4'b0111; bus.flush_i = 1'b1;
    #1;
    checks++;
    if (bus.stall_o !== 1'b0) begin
      errors++;
      $display("FAIL fl_stall got stall_o=%b expected 0", bus.stall_o);
    end
    tick();
    checks++;
    if (bus.ex_rd !== 5'd0 || bus.ex_reg_write !== 1'b0 || bus.Operation !== 4'b0000 ||
        bus.ex_mem_read !== 1'b0) begin
      errors++;
      $display("FAIL fl_bubble got rd=%0d rw=%b op=%b mr=%b expected 0 0 0000 0",
               bus.ex_rd, bus.ex_reg_write, bus.Operation, bus.ex_mem_read);
    end
    checks++;
    if (bus.stall_count !== 4'(exp_cnt)) begin
      errors++;
      $display("FAIL fl_count got %0d expected %0d", bus.stall_count, exp_cnt);
    end
  endtask

  task automatic test_saturation();
    for (int i = 0; i < 18; i++) begin
      issue_load(5'd7);
      clear_inputs();
      bus.id_rs1 = 5'd7; bus.id_use_rs1 = 1'b1;
      #1;
      if (i == 17) begin
        checks++;
        if (bus.stall_o !== 1'b1) begin
          errors++;
          $display("FAIL sat_stall got stall_o=%b expected 1", bus.stall_o);
        end
      end
      tick();
      exp_cnt = (exp_cnt == 15) ? 15 : exp_cnt + 1;
      if (i == 15) begin
        checks++;
        if (bus.stall_count !== 4'hF) begin
          errors++;
          $display("FAIL sat_reach got %h expected f", bus.stall_count);
        end
      end
    end
    checks++;
    if (bus.stall_count !== 4'(exp_cnt) || bus.stall_count !== 4'hF) begin
      errors++;
      $display("FAIL sat_hold got %h expected f", bus.stall_count);
    end
  endtask

  initial begin
    checks  = 0;
    errors  = 0;
    exp_cnt = 0;
    reset   = 1'b1;
    clear_inputs();
    test_reset();
    test_pass_through();
    test_forward_priority();
    test_load_use();
    test_flush_hazard();
    test_saturation();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
